// File: rtl/iob_merge_pkg.sv
// Shared IOb field layout and width helpers for the N-to-1 merger.
// REQ = {avalid, addr, wdata, wstrb}, RESP = {rdata, rvalid, ready}, LSB first from the right.
package iob_merge_pkg;

  typedef enum logic {
    ReqWrite,
    ReqRead
  } req_kind_e;

  localparam int unsigned RespReadyBit  = 0;
  localparam int unsigned RespRvalidBit = 1;
  localparam int unsigned RespRdataLsb  = 2;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned req_w(input int unsigned data_w, input int unsigned addr_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int unsigned resp_w(input int unsigned data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/iob_merge_if.sv
// Flat IOb buses around the merger: N master-side slots plus one slave-side slot.
// "slave" is the merger's view; "master" is the view of whatever surrounds it.
interface iob_merge_if
  import iob_merge_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned N_MASTERS = 2
);

  localparam int unsigned ReqW  = req_w(DATA_W, ADDR_W);
  localparam int unsigned RespW = resp_w(DATA_W);

  logic [N_MASTERS*ReqW-1:0]  m_req;
  logic [N_MASTERS*RespW-1:0] m_resp;
  logic [ReqW-1:0]            s_req;
  logic [RespW-1:0]           s_resp;

  modport master (
    output m_req,
    output s_resp,
    input  m_resp,
    input  s_req
  );

  modport slave (
    input  m_req,
    input  s_resp,
    output m_resp,
    output s_req
  );

endinterface

// File: rtl/iob_merge_rr_arb.sv
// Zero-cycle round-robin arbiter; a locked grant overrides the scan until accepted.
module iob_merge_rr_arb #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned NB        = 1
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [NB-1:0]        rr_ptr_i,
  input  logic                 lock_i,
  input  logic [NB-1:0]        lock_id_i,
  output logic [NB-1:0]        grant_o,
  output logic                 any_req_o
);

  logic        found;
  int unsigned idx;

  always_comb begin
    any_req_o = |req_i;
    grant_o   = rr_ptr_i;
    found     = 1'b0;
    idx       = 0;
    if (lock_i) begin
      grant_o = lock_id_i;
    end else begin
      for (int k = 0; k < N_MASTERS; k++) begin
        idx = (int'(rr_ptr_i) + k) % N_MASTERS;
        if (!found && req_i[idx]) begin
          grant_o = NB'(idx);
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/iob_merge.sv
// N-master to 1-slave IOb merger: round-robin request arbitration with an in-order
// owner FIFO that routes each read response back to the master that issued it.
module iob_merge
  import iob_merge_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic       cke_i,
  iob_merge_if.slave bus_io,
  output logic       err_o
);

  localparam int unsigned NB      = idx_w(N_MASTERS);
  localparam int unsigned WSTRB_W = DATA_W / 8;
  localparam int unsigned REQ_W   = req_w(DATA_W, ADDR_W);
  localparam int unsigned RESP_W  = resp_w(DATA_W);
  localparam int unsigned PTR_W   = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W   = PTR_W + 1;

  logic [NB-1:0]    rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [NB-1:0]    lock_id_q, lock_id_d;
  logic [NB-1:0]    fifo_q [MAX_OUTST];
  logic [NB-1:0]    fifo_d [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [N_MASTERS-1:0]        req_vld;
  logic [NB-1:0]               grant;
  logic                        any_req;
  logic [REQ_W-1:0]            g_req;
  req_kind_e                   g_kind;
  logic                        full, empty, block, s_go;
  logic                        s_ready, s_rvalid;
  logic [DATA_W-1:0]           s_rdata;
  logic                        accept, push, pop;
  logic [NB-1:0]               owner;
  logic [N_MASTERS*RESP_W-1:0] m_resp;

  always_comb begin
    req_vld = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      req_vld[i] = bus_io.m_req[i*REQ_W + REQ_W - 1];
    end
  end

  iob_merge_rr_arb #(
    .N_MASTERS(N_MASTERS),
    .NB       (NB)
  ) u_arb (
    .req_i    (req_vld),
    .rr_ptr_i (rr_ptr_q),
    .lock_i   (lock_q),
    .lock_id_i(lock_id_q),
    .grant_o  (grant),
    .any_req_o(any_req)
  );

  assign g_req    = bus_io.m_req[int'(grant)*REQ_W +: REQ_W];
  assign g_kind   = (g_req[WSTRB_W-1:0] == '0) ? ReqRead : ReqWrite;
  assign full     = (count_q == CNT_W'(MAX_OUTST));
  assign empty    = (count_q == '0);
  // A full FIFO stalls reads even when a pop lands in the same cycle.
  assign block    = (g_kind == ReqRead) && full;
  assign s_go     = any_req && !block;
  assign s_ready  = bus_io.s_resp[RespReadyBit];
  assign s_rvalid = bus_io.s_resp[RespRvalidBit];
  assign s_rdata  = bus_io.s_resp[RespRdataLsb +: DATA_W];
  assign accept   = s_go && g_req[REQ_W-1] && s_ready;
  assign push     = accept && (g_kind == ReqRead);
  assign pop      = s_rvalid && !empty;
  assign owner    = fifo_q[rd_ptr_q];

  assign bus_io.s_req  = s_go ? g_req : '0;
  assign bus_io.m_resp = m_resp;
  assign err_o         = err_q;

  always_comb begin
    m_resp = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (pop && (owner == NB'(i))) begin
        m_resp[i*RESP_W + RespRvalidBit]           = 1'b1;
        m_resp[i*RESP_W + RespRdataLsb +: DATA_W] = s_rdata;
      end
      if (s_go && (grant == NB'(i))) begin
        m_resp[i*RESP_W + RespReadyBit] = s_ready;
      end
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_d     = err_q;

    if (accept) begin
      rr_ptr_d = (grant == NB'(N_MASTERS - 1)) ? '0 : grant + 1'b1;
      lock_d   = 1'b0;
    end else if (g_req[REQ_W-1]) begin
      // Pin the grant so a stalled master cannot be overtaken mid-handshake.
      lock_d    = 1'b1;
      lock_id_d = grant;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = grant;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (s_rvalid && empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (cke_i) begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      for (int i = 0; i < MAX_OUTST; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

endmodule

// File: tb/tb_iob_merge.sv
// Directed bench for iob_merge with a queue scoreboard: stimulus pushes expected
// accepts/responses, a negedge monitor pops and compares whatever the DUT presents.
module tb_iob_merge;
  import iob_merge_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NM = 2;
  localparam int unsigned MO = 4;
  localparam int unsigned WS = DW / 8;
  localparam int unsigned RQ = req_w(DW, AW);
  localparam int unsigned RS = resp_w(DW);

  typedef struct {
    int            m;
    logic [RQ-1:0] req;
  } acc_t;

  typedef struct {
    int            m;
    logic [DW-1:0] d;
  } rsp_t;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } pend_t;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  logic cke    = 1'b1;
  logic err;

  logic [NM*RQ-1:0] m_req_v;
  logic             s_ready;
  logic             s_rvalid;
  logic [DW-1:0]    s_rdata;
  logic             hold;
  logic             inject;

  acc_t  exp_acc[$];
  rsp_t  exp_rsp[$];
  pend_t pend[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  iob_merge_if #(.DATA_W(DW), .ADDR_W(AW), .N_MASTERS(NM)) bus ();

  assign bus.m_req  = m_req_v;
  assign bus.s_resp = {s_rdata, s_rvalid, s_ready};

  iob_merge #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .N_MASTERS(NM),
    .MAX_OUTST(MO)
  ) dut (
    .clk_i   (clk),
    .arst_n_i(arst_n),
    .cke_i   (cke),
    .bus_io  (bus),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  function automatic logic [RQ-1:0] mk(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                        input logic [WS-1:0] s);
    return {1'b1, a, d, s};
  endfunction

  function automatic logic m_ready(input int i);
    return bus.m_resp[i*RS];
  endfunction

  function automatic logic m_rvalid(input int i);
    return bus.m_resp[i*RS+1];
  endfunction

  task automatic chk(input string name, input logic [RQ-1:0] act, input logic [RQ-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_m(input int i, input logic [RQ-1:0] req);
    m_req_v[i*RQ +: RQ] = req;
  endtask

  function automatic logic any_avalid();
    logic r = 1'b0;
    for (int i = 0; i < NM; i++) r |= m_req_v[i*RQ + RQ - 1];
    return r;
  endfunction

  // One master, one request; returns right after the accepting edge.
  task automatic issue(input int i, input logic [RQ-1:0] req);
    logic ok = 1'b0;
    exp_acc.push_back('{i, req});
    set_m(i, req);
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = m_ready(i);
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout m%0d: got no ready expected ready", i);
    end
    set_m(i, '0);
  endtask

  // Serve all currently raised requests, dropping each one once its ready is seen.
  task automatic run_all(output int n);
    logic [NM-1:0] take;
    n = 0;
    for (int c = 0; c < 30 && any_avalid(); c++) begin
      @(negedge clk);
      for (int i = 0; i < NM; i++) take[i] = m_req_v[i*RQ + RQ - 1] && m_ready(i);
      @(posedge clk);
      #1;
      for (int i = 0; i < NM; i++) if (take[i]) set_m(i, '0);
      n++;
    end
    if (any_avalid()) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got pending requests expected none");
      m_req_v = '0;
    end
  endtask

  // Slave: read data = addr >> 4, returned two cycles after accept unless held.
  initial begin
    pend_t p;
    s_rvalid = 1'b0;
    s_rdata  = '0;
    forever begin
      @(negedge clk);
      if (arst_n && bus.s_req[RQ-1] && s_ready && bus.s_req[WS-1:0] == '0)
        pend.push_back('{cyc + 2, bus.s_req[WS+DW +: AW] >> 4});
      @(posedge clk);
      #1;
      cyc++;
      if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
        p        = pend.pop_front();
        s_rvalid = 1'b1;
        s_rdata  = p.d;
      end else if (inject) begin
        s_rvalid = 1'b1;
        s_rdata  = 32'hDEAD;
      end else begin
        s_rvalid = 1'b0;
        s_rdata  = '0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    acc_t a;
    rsp_t r;
    if (arst_n) begin
      if (bus.s_req[RQ-1] && s_ready) begin
        checks++;
        if (exp_acc.size() == 0) begin
          errors++;
          $display("FAIL acc_unexpected: got %h expected none", bus.s_req);
        end else begin
          a = exp_acc.pop_front();
          if (bus.s_req !== a.req || m_ready(a.m) !== 1'b1) begin
            errors++;
            $display("FAIL acc_m%0d: got req %h ready %b expected req %h ready 1",
                     a.m, bus.s_req, m_ready(a.m), a.req);
          end
        end
      end
      for (int i = 0; i < NM; i++) begin
        if (m_rvalid(i)) begin
          checks++;
          if (exp_rsp.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected m%0d: got %h expected none", i,
                     bus.m_resp[i*RS+2 +: DW]);
          end else begin
            r = exp_rsp.pop_front();
            if (r.m != i || bus.m_resp[i*RS+2 +: DW] !== r.d) begin
              errors++;
              $display("FAIL rsp: got m%0d data %h expected m%0d data %h", i,
                       bus.m_resp[i*RS+2 +: DW], r.m, r.d);
            end
          end
        end else if (bus.m_resp[i*RS+2 +: DW] !== '0) begin
          checks++;
          errors++;
          $display("FAIL rdata_leak m%0d: got %h expected 0", i, bus.m_resp[i*RS+2 +: DW]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [RQ-1:0] w0, w1, w2, w3, w4, r1, r5;
    m_req_v = '0;
    s_ready = 1'b0;
    hold    = 1'b0;
    inject  = 1'b0;

    // Reset and idle
    repeat (2) @(negedge clk);
    chk("rst_sreq", bus.s_req, '0);
    chk("rst_mresp", RQ'(bus.m_resp), '0);
    chk("rst_err", RQ'(err), '0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    chk("idle_sreq", bus.s_req, '0);
    chk("idle_mresp", RQ'(bus.m_resp), '0);

    // Simultaneous writes, round-robin order
    @(posedge clk);
    #1 s_ready = 1'b1;
    w0 = mk(32'h100, 32'h11, 4'hF);
    w1 = mk(32'h104, 32'h22, 4'hF);
    exp_acc.push_back('{0, w0});
    exp_acc.push_back('{1, w1});
    set_m(0, w0);
    set_m(1, w1);
    run_all(n);
    chk("wr_cycles_a", RQ'(n), RQ'(2));
    w2 = mk(32'h108, 32'h33, 4'h3);
    w3 = mk(32'h10C, 32'h44, 4'hC);
    exp_acc.push_back('{0, w2});
    exp_acc.push_back('{1, w3});
    set_m(0, w2);
    set_m(1, w3);
    run_all(n);
    chk("wr_cycles_b", RQ'(n), RQ'(2));

    // Lock: m1 stalled read keeps the grant while m0 waits
    s_ready = 1'b0;
    r1 = mk(32'h10, '0, '0);
    set_m(1, r1);
    @(negedge clk);
    chk("lock_first", bus.s_req, r1);
    @(posedge clk);
    #1;
    w4 = mk(32'h200, 32'h55, 4'hF);
    set_m(0, w4);
    repeat (3) begin
      @(negedge clk);
      chk("lock_hold", bus.s_req, r1);
      chk("lock_m0_rdy", RQ'(m_ready(0)), '0);
    end
    @(posedge clk);
    #1 s_ready = 1'b1;
    exp_acc.push_back('{1, r1});
    exp_acc.push_back('{0, w4});
    exp_rsp.push_back('{1, 32'h1});
    run_all(n);
    chk("lock_cycles", RQ'(n), RQ'(2));

    // Interleaved reads routed back to their owners
    exp_rsp.push_back('{0, 32'hA});
    exp_rsp.push_back('{1, 32'hB});
    exp_rsp.push_back('{0, 32'hC});
    issue(0, mk(32'hA0, '0, '0));
    issue(1, mk(32'hB0, '0, '0));
    issue(0, mk(32'hC0, '0, '0));
    repeat (8) @(negedge clk);

    // Owner FIFO full: fifth read blocked until a pop
    @(posedge clk);
    #1 hold = 1'b1;
    exp_rsp.push_back('{0, 32'h5});
    exp_rsp.push_back('{1, 32'h6});
    exp_rsp.push_back('{0, 32'h7});
    exp_rsp.push_back('{1, 32'h8});
    exp_rsp.push_back('{0, 32'h9});
    issue(0, mk(32'h50, '0, '0));
    issue(1, mk(32'h60, '0, '0));
    issue(0, mk(32'h70, '0, '0));
    issue(1, mk(32'h80, '0, '0));
    r5 = mk(32'h90, '0, '0);
    exp_acc.push_back('{0, r5});
    set_m(0, r5);
    repeat (2) begin
      @(negedge clk);
      chk("full_savalid", RQ'(bus.s_req[RQ-1]), '0);
      chk("full_mready", RQ'(m_ready(0)), '0);
    end
    hold = 1'b0;
    @(negedge clk);
    chk("full_pop_rvalid", RQ'(m_rvalid(0)), RQ'(1));
    chk("full_pop_block", RQ'(bus.s_req[RQ-1]), '0);
    @(negedge clk);
    chk("after_pop_savalid", RQ'(bus.s_req[RQ-1]), RQ'(1));
    chk("after_pop_mready", RQ'(m_ready(0)), RQ'(1));
    @(posedge clk);
    #1 set_m(0, '0);
    repeat (10) @(negedge clk);

    // Spurious response with nothing outstanding
    chk("pre_err", RQ'(err), '0);
    inject = 1'b1;
    @(posedge clk);
    #2 inject = 1'b0;
    @(negedge clk);
    chk("spur_m0_rvalid", RQ'(m_rvalid(0)), '0);
    chk("spur_m1_rvalid", RQ'(m_rvalid(1)), '0);
    chk("spur_err_same", RQ'(err), '0);
    @(negedge clk);
    chk("spur_err_set", RQ'(err), RQ'(1));
    repeat (3) @(negedge clk);
    chk("spur_err_sticky", RQ'(err), RQ'(1));
    @(posedge clk);
    #1 arst_n = 1'b0;
    @(negedge clk);
    chk("rst_err_clear", RQ'(err), '0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);

    chk("acc_queue_empty", RQ'(exp_acc.size()), '0);
    chk("rsp_queue_empty", RQ'(exp_rsp.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
